// File: rtl/test_gap_if.sv
// Bundle between the rng_lcg lanes, the gap-test stage and the host readout:
// the per-strobe sample lanes in one direction, the histogram and totals in the other.
interface test_gap_if #(
    parameter int LANES = 4,
    parameter int W     = 32,
    parameter int NBINS = 32
);
    logic                        tst_en;
    logic [LANES-1:0][W-1:0]     num;
    logic [NBINS-1:0][63:0]      res;
    logic [63:0]                 gap_total;
    logic [63:0]                 sample_total;

    modport master (
        output tst_en, num,
        input  res, gap_total, sample_total
    );

    modport slave (
        input  tst_en, num,
        output res, gap_total, sample_total
    );
endinterface

// File: rtl/test_gap.sv
// Gap-test statistics stage: per-lane hit/miss FSM measuring misses between hits,
// followed by a two-stage pipeline that bins completed gaps into a 64-bit histogram.
module test_gap #(
    parameter int           LANES = 4,
    parameter int           W     = 32,
    parameter int           NBINS = 32,
    parameter logic [W-1:0] LO    = '0,
    parameter logic [W-1:0] HI    = {1'b1, {(W-1){1'b0}}}
) (
    input  logic         clk,
    input  logic         reset,
    test_gap_if.slave    gap_if
);

    localparam int            GW      = $clog2(NBINS);
    localparam int            CW      = $clog2(LANES + 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(NBINS - 1);
    localparam logic [W-1:0]  SPAN    = HI - LO;

    typedef enum logic {
        DISARMED = 1'b0,
        ARMED    = 1'b1
    } lane_state_e;

    lane_state_e   state_q [LANES];
    lane_state_e   state_d [LANES];
    logic [GW-1:0] gap_q   [LANES];
    logic [GW-1:0] gap_d   [LANES];
    logic          hit     [LANES];
    logic          emit_d  [LANES];

    logic          s1_vld_q;
    logic          s1_emit_q [LANES];
    logic [GW-1:0] s1_bin_q  [LANES];

    logic [NBINS-1:0][63:0] res_q, res_d;
    logic [63:0]            gap_total_q, gap_total_d;
    logic [63:0]            sample_total_q, sample_total_d;
    logic [CW-1:0]          bin_cnt;
    logic [CW-1:0]          emit_cnt;

    // Lane FSMs and gap counters: everything holds unless the strobe is high.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
            state_d[l] = state_q[l];
            gap_d[l]   = gap_q[l];
            emit_d[l]  = 1'b0;
            // Offset compare covers [LO,HI) with one unsigned test; values below LO wrap high.
            hit[l]     = (gap_if.num[l] - LO) < SPAN;
            if (gap_if.tst_en) begin
                unique case (state_q[l])
                    DISARMED: begin
                        if (hit[l]) begin
                            state_d[l] = ARMED;
                            gap_d[l]   = '0;
                        end
                    end
                    ARMED: begin
                        if (hit[l]) begin
                            emit_d[l] = 1'b1;
                            gap_d[l]  = '0;
                        end else if (gap_q[l] != GAP_MAX) begin
                            gap_d[l] = gap_q[l] + 1'b1;
                        end
                    end
                    default: state_d[l] = DISARMED;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int l = 0; l < LANES; l++) begin
                state_q[l]   <= DISARMED;
                gap_q[l]     <= '0;
                s1_emit_q[l] <= 1'b0;
                s1_bin_q[l]  <= '0;
            end
            s1_vld_q <= 1'b0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                state_q[l]   <= state_d[l];
                gap_q[l]     <= gap_d[l];
                s1_emit_q[l] <= emit_d[l];
                s1_bin_q[l]  <= gap_q[l];
            end
            s1_vld_q <= gap_if.tst_en;
        end
    end

    // S2 accumulation: per-bin lane count so same-bin collisions in one cycle all land.
    always_comb begin
        res_d          = res_q;
        gap_total_d    = gap_total_q;
        sample_total_d = sample_total_q;
        bin_cnt        = '0;
        emit_cnt       = '0;
        if (s1_vld_q) begin
            for (int k = 0; k < NBINS; k++) begin
                bin_cnt = '0;
                for (int l = 0; l < LANES; l++) begin
                    if (s1_emit_q[l] && (s1_bin_q[l] == GW'(k))) begin
                        bin_cnt = bin_cnt + CW'(1);
                    end
                end
                res_d[k] = res_q[k] + 64'(bin_cnt);
            end
            for (int l = 0; l < LANES; l++) begin
                emit_cnt = emit_cnt + CW'(s1_emit_q[l]);
            end
            gap_total_d    = gap_total_q + 64'(emit_cnt);
            sample_total_d = sample_total_q + 64'(LANES);
        end
    end

    // NOTE: the histogram is a register bank, not a RAM, so it is cleared by reset like any other state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q          <= '0;
            gap_total_q    <= '0;
            sample_total_q <= '0;
        end else begin
            res_q          <= res_d;
            gap_total_q    <= gap_total_d;
            sample_total_q <= sample_total_d;
        end
    end

    assign gap_if.res          = res_q;
    assign gap_if.gap_total    = gap_total_q;
    assign gap_if.sample_total = sample_total_q;

endmodule

// File: tb/tb_test_gap.sv
// Self-checking bench for test_gap: a behavioural lane model feeds a snapshot queue
// that is compared against the DUT outputs one pipeline step later.
module tb_test_gap;

    localparam int          LANES = 4;
    localparam int          W     = 32;
    localparam int          NBINS = 32;
    localparam logic [31:0] LO    = 32'h0000_0000;
    localparam logic [31:0] HI    = 32'h8000_0000;
    localparam logic [31:0] HIT   = 32'h0000_0000;
    localparam logic [31:0] MISS  = 32'hFFFF_FFFF;

    typedef logic [LANES-1:0][31:0] lanes_t;

    typedef struct packed {
        logic [NBINS-1:0][63:0] res;
        logic [63:0]            gt;
        logic [63:0]            st;
    } snap_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    test_gap_if #(.LANES(LANES), .W(W), .NBINS(NBINS)) gif ();

    test_gap #(
        .LANES(LANES), .W(W), .NBINS(NBINS), .LO(LO), .HI(HI)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .gap_if (gif)
    );

    snap_t model;
    snap_t exp_q[$];
    bit    armed [LANES];
    int    gap   [LANES];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_hit(input logic [31:0] n);
        return (longint'(n) >= longint'(LO)) && (longint'(n) < longint'(HI));
    endfunction

    function automatic lanes_t lane0(input logic [31:0] v);
        return {MISS, MISS, MISS, v};
    endfunction

    task automatic model_strobe(input lanes_t n);
        for (int l = 0; l < LANES; l++) begin
            if (!armed[l]) begin
                if (is_hit(n[l])) begin
                    armed[l] = 1'b1;
                    gap[l]   = 0;
                end
            end else if (is_hit(n[l])) begin
                model.res[gap[l]] = model.res[gap[l]] + 64'd1;
                model.gt          = model.gt + 64'd1;
                gap[l]            = 0;
            end else if (gap[l] < NBINS - 1) begin
                gap[l] = gap[l] + 1;
            end
        end
        model.st = model.st + 64'(LANES);
    endtask

    task automatic compare_snap(input string tag, input snap_t e);
        for (int k = 0; k < NBINS; k++)
            check($sformatf("%s res[%0d]", tag, k), gif.res[k], e.res[k]);
        check({tag, " gap_total"}, gif.gap_total, e.gt);
        check({tag, " sample_total"}, gif.sample_total, e.st);
    endtask

    task automatic step(input string tag, input bit en, input lanes_t n);
        gif.tst_en = en;
        gif.num    = n;
        if (en) model_strobe(n);
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        if (exp_q.size() > 1) compare_snap(tag, exp_q.pop_front());
    endtask

    task automatic flush(input string tag);
        step(tag, 1'b0, lane0(MISS));
        step(tag, 1'b0, lane0(MISS));
    endtask

    // Reset with live random traffic; outputs must stay zero every cycle.
    task automatic do_reset(input string tag);
        snap_t zero;
        zero  = '0;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            gif.tst_en = 1'b1;
            for (int l = 0; l < LANES; l++) gif.num[l] = $urandom;
            #1;
            compare_snap({tag, " in_reset"}, zero);
            @(posedge clk);
            #1;
        end
        compare_snap({tag, " in_reset"}, zero);
        reset = 1'b0;
        model = '0;
        for (int l = 0; l < LANES; l++) begin
            armed[l] = 1'b0;
            gap[l]   = 0;
        end
        exp_q.delete();
        exp_q.push_back(model);
    endtask

    function automatic logic [31:0] rand_sample();
        case ($urandom_range(5))
            0:       return LO;
            1:       return HI;
            2:       return HI - 32'd1;
            3:       return MISS;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        lanes_t n;
        logic [63:0] sum;
        reset      = 1'b0;
        gif.tst_en = 1'b0;
        gif.num    = '0;
        #1;

        // Reset holds everything at zero under live traffic.
        do_reset("t1");

        // Single gap of length 2 on lane 0.
        do_reset("t2");
        step("t2", 1'b1, lane0(HIT));
        step("t2", 1'b1, lane0(MISS));
        step("t2", 1'b1, lane0(MISS));
        step("t2", 1'b1, lane0(HIT));
        flush("t2");
        check("t2 res2", gif.res[2], 64'd1);
        check("t2 res0", gif.res[0], 64'd0);
        check("t2 gap_total", gif.gap_total, 64'd1);
        check("t2 sample_total", gif.sample_total, 64'd16);

        // All lanes hit the same bin in the same cycle.
        do_reset("t3");
        for (int i = 0; i < 10; i++) step("t3", 1'b1, {HIT, HIT, HIT, HIT});
        flush("t3");
        check("t3 res0", gif.res[0], 64'd36);
        check("t3 gap_total", gif.gap_total, 64'd36);
        check("t3 sample_total", gif.sample_total, 64'd40);

        // Saturation at the last bin, then num == HI counts as a miss.
        do_reset("t4");
        step("t4", 1'b1, lane0(HIT));
        for (int i = 0; i < 40; i++) step("t4", 1'b1, lane0(MISS));
        step("t4", 1'b1, lane0(HIT));
        flush("t4");
        check("t4 res31", gif.res[31], 64'd1);
        check("t4 res30", gif.res[30], 64'd0);
        step("t4", 1'b1, lane0(HI));
        step("t4", 1'b1, lane0(HIT));
        flush("t4");
        check("t4 res1", gif.res[1], 64'd1);
        check("t4 gap_total", gif.gap_total, 64'd2);

        // Idle cycles with hit data are ignored.
        do_reset("t5");
        step("t5", 1'b1, lane0(HIT));
        for (int i = 0; i < 5; i++) step("t5", 1'b0, {HIT, HIT, HIT, HIT});
        step("t5", 1'b1, lane0(MISS));
        step("t5", 1'b1, lane0(HIT));
        flush("t5");
        check("t5 res1", gif.res[1], 64'd1);
        check("t5 sample_total", gif.sample_total, 64'd12);
        check("t5 gap_total", gif.gap_total, 64'd1);

        // Mid-operation reset drops in-flight data and disarms every lane.
        do_reset("t6");
        step("t6", 1'b1, lane0(HIT));
        step("t6", 1'b1, lane0(MISS));
        do_reset("t6r");
        step("t6", 1'b1, lane0(HIT));
        step("t6", 1'b1, lane0(MISS));
        step("t6", 1'b1, lane0(HIT));
        flush("t6");
        check("t6 res1", gif.res[1], 64'd1);
        check("t6 gap_total", gif.gap_total, 64'd1);

        // Random traffic with boundary-heavy samples and gaps in the strobe.
        do_reset("rnd");
        for (int i = 0; i < 400; i++) begin
            for (int l = 0; l < LANES; l++) n[l] = rand_sample();
            step("rnd", ($urandom_range(3) != 0), n);
        end
        flush("rnd");
        sum = '0;
        for (int k = 0; k < NBINS; k++) sum = sum + gif.res[k];
        check("rnd sum_res", sum, model.gt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
